// File: rtl/switch_buf_arbiter.sv
// switch_buf_arbiter: round-robin arbitration of NUM_PORTS ingress writers into
// one simple dual-port memory run as a circular FIFO, drained by a single
// egress reader. The memory's registered read latency is hidden behind a
// valid-qualified read port (rd_valid one cycle after each accepted pop).
module switch_buf_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int MEM_SIZE   = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            wr_req,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_PORTS-1:0]            wr_grant,
    input  logic                            rd_req,
    output logic                            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [ADDR_WIDTH:0]             count,
    output logic                            full,
    output logic                            empty,
    output logic [ADDR_WIDTH-1:0]           mem_ra,
    output logic [ADDR_WIDTH-1:0]           mem_wa,
    output logic [DATA_WIDTH-1:0]           mem_d,
    output logic                            mem_write,
    input  logic [DATA_WIDTH-1:0]           mem_q
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MEM_SIZE);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         cnt;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         rr_next;
    logic [PW-1:0]         gnt_idx;
    logic                  gnt_any;
    logic                  push_p0;
    logic                  pop_p0;
    logic                  vld_p1;

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);
    assign count = cnt;

    // Round-robin scan starting at rr_ptr; full blocks every grant, even with a pop pending.
    always_comb begin
        int idx;
        logic [PW-1:0] sel;
        wr_grant = '0;
        gnt_idx  = '0;
        gnt_any  = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            sel = PW'(idx);
            if (!full && !gnt_any && wr_req[sel]) begin
                gnt_any       = 1'b1;
                gnt_idx       = sel;
                wr_grant[sel] = 1'b1;
            end
        end
    end

    // Steer the granted port's word onto the memory write bus; zero when idle.
    always_comb begin
        mem_d = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr_grant[i]) begin
                mem_d = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rr_next   = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
    assign push_p0   = gnt_any;
    assign pop_p0    = rd_req && !empty;

    assign mem_write = gnt_any;
    assign mem_wa    = wr_ptr;
    assign mem_ra    = rd_ptr;

    // ---- stage p0 -> p1: pointer/occupancy update and read-valid alignment with mem_q ----
    // FIFO control state; reset drops any in-flight read but leaves memory untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rr_ptr <= '0;
            vld_p1 <= 1'b0;
        end else begin
            if (push_p0) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                rr_ptr <= rr_next;
            end
            if (pop_p0) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            vld_p1 <= pop_p0;
            case ({push_p0, pop_p0})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign rd_valid = vld_p1;
    assign rd_data  = mem_q;

endmodule
